serial_packet_router: RTL

//  Parametrised successor to the single-channel serial transmitter datapath. It adds its own

---
 rtl/serial_pkt_pkg.sv | 15 +
 rtl/load_down_counter.sv | 28 ++
 rtl/serial_packet_router.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_pkt_pkg.sv
// Shared types and constants for the serial packet router.
package serial_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_CH  = 3'd1,
    HDR_LEN = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/load_down_counter.sv
// Payload length counter: loaded MSB first by shifting, then counted down once per payload bit.
module load_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (shift_en) begin
      count <= {count[CNT_W-2:0], shift_in};
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign is_one  = (count == CNT_W'(1));
  assign is_zero = (count == '0);

endmodule

// File: rtl/serial_packet_router.sv
// Framed serial stream parser that forwards payload bits to one of NUM_CH outputs.
// Optional even-parity check over the payload is enabled by defining PARITY_EN.
module serial_packet_router
  import serial_pkt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  output logic [NUM_CH-1:0] serOut,
  output logic [NUM_CH-1:0] valid,
  output logic [CNT_W-1:0]  remaining,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int BC_W = $clog2((CNT_W > CH_W) ? CNT_W : CH_W) + 1;

`ifdef PARITY_EN
  localparam state_t PAY_END = PARITY;
`else
  localparam state_t PAY_END = DONE;
`endif

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch_reg;
  logic [BC_W-1:0]   bitcnt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len_next;
  logic              is_one, is_zero;
  logic              shift_en, dec;
  logic              hdr_ch_last, hdr_len_last;
  logic              bad_ch;

  assign hdr_ch_last  = (bitcnt == BC_W'(CH_W - 1));
  assign hdr_len_last = (bitcnt == BC_W'(CNT_W - 1));
  assign len_next     = {count[CNT_W-2:0], serIn};
  assign shift_en     = (state == HDR_LEN);
  assign dec          = (state == DATA) && !is_zero;

  load_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .shift_in (serIn),
    .dec      (dec),
    .count    (count),
    .is_one   (is_one),
    .is_zero  (is_zero)
  );

  // Out-of-range channel codes exist only when NUM_CH is not a power of two.
  generate
    if ((1 << CH_W) == NUM_CH) begin : g_pow2
      assign bad_ch = 1'b0;
    end else begin : g_npow2
      assign bad_ch = ({1'b0, ch_reg} >= (CH_W + 1)'(NUM_CH));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch_reg <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == HDR_CH) begin
        ch_reg <= (ch_reg << 1) | CH_W'(serIn);
      end
      if ((state == HDR_CH && !hdr_ch_last) || (state == HDR_LEN && !hdr_len_last)) begin
        bitcnt <= bitcnt + BC_W'(1);
      end else begin
        bitcnt <= '0;
      end
    end
  end

`ifdef PARITY_EN
  logic par_acc, par_err;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else if (state == DATA) begin
      par_acc <= par_acc ^ serIn;
    end else if (state == PARITY) begin
      par_err <= par_acc ^ serIn;
    end
  end

  assign err = done && (bad_ch || par_err);
`else
  assign err = done && bad_ch;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (serIn == START_BIT) state_nxt = HDR_CH;
      HDR_CH:  if (hdr_ch_last) state_nxt = HDR_LEN;
      HDR_LEN: if (hdr_len_last) state_nxt = (len_next != '0) ? DATA : PAY_END;
      // Leaving on is_zero as well guards against the counter ever wrapping.
      DATA:    if (is_one || is_zero) state_nxt = PAY_END;
      PARITY:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    serOut    = '0;
    valid     = '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    remaining = (state == HDR_LEN || state == DATA) ? count : '0;
    if (state == DATA && !bad_ch) begin
      valid[ch_reg]  = 1'b1;
      serOut[ch_reg] = serIn;
    end
  end

endmodule
